// File: rtl/serial_adder.sv
// serial_adder
//   Digit-serial adder/subtractor. Operands of WIDTH bits are processed DIGIT
//   bits per clock, least significant slice first, with the carry held in a
//   register between slices. One operation takes N = WIDTH/DIGIT RUN cycles.
//   Subtraction is done as A + ~B + ~C_IN, so CARRY=1 means "no borrow".
//
// Ports
//   CLK       in   rising-edge clock
//   RESET     in   asynchronous, active-high reset
//   START     in   request, accepted on an edge where READY=1
//   SUB       in   0: A + B + C_IN, 1: A - B - C_IN (sampled with START)
//   A, B      in   WIDTH-bit operands (sampled with START)
//   C_IN      in   carry-in / borrow-in (sampled with START)
//   READY     out  a START on the next edge will be accepted
//   DONE      out  one-cycle pulse, results were updated on the last edge
//   SUM       out  WIDTH-bit result, modulo 2^WIDTH
//   CARRY     out  carry-out of the MSB
//   OVERFLOW  out  two's-complement overflow of the operation
//
// States
//   IDLE | waiting for START, previous result held
//   RUN  | one slice per edge, slice counter cnt_q selects the slice
//   FIN  | result just written, DONE high, START accepted again

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVERFLOW
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Shift amount must reach WIDTH-DIGIT; one spare bit keeps the product exact.
  localparam int SW = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - DIGIT);
  localparam logic [CW-1:0]    LAST_CNT   = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // B, already inverted for subtraction
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SW-1:0]    shamt;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] acc_ins;

  // Slice datapath: select the current slice by shifting it down to bit 0,
  // add, then merge the DIGIT-bit result back into the accumulator.
  always_comb begin
    shamt     = SW'(cnt_q) * SW'(DIGIT);
    slice_a   = DIGIT'(a_q >> shamt);
    slice_b   = DIGIT'(b_q >> shamt);
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry_q};
    acc_ins   = (acc_q & ~(SLICE_MASK << shamt))
              | (WIDTH'(slice_sum[DIGIT-1:0]) << shamt);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          a_d     = A;
          b_d     = SUB ? ~B : B;
          carry_d = SUB ? ~C_IN : C_IN;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d   = acc_ins;
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = FIN;
          sum_d   = acc_ins;
          cout_d  = slice_sum[DIGIT];
          // Overflow: both addends share a sign that the result does not.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (acc_ins[WIDTH-1] != a_q[WIDTH-1]);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status decodes come straight from the state register.
  assign READY    = (state_q != RUN);
  assign DONE     = (state_q == FIN);
  assign SUM      = sum_q;
  assign CARRY    = cout_q;
  assign OVERFLOW = ovf_q;

endmodule
